inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
Initiator end of the 12-bit inst/inst_en device bus. It fetches 16-bit program words from an external synchronous ROM and dispatches each word to one of up to DEVICES target devices, such as register banks, as a single-cycle inst_en pulse. It also executes a small set of its own control instructions: jump, timed wait and halt. It sits at the top of the datapath and replaces hand-driven inst/inst_en stimulus.

Parameters:
DEVICES, 4, number of target devices; width of inst_en (1..15)
PC_WIDTH, 8, program counter / ROM address width

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
rom_addr  out  PC_WIDTH  ROM read address, equal to the current pc register
rom_data  in  16  ROM word; valid one cycle after rom_addr (registered ROM)
inst  out  12  instruction to devices, {opcode[3:0], imm[7:0]}
inst_en  out  DEVICES  one-hot device enable, at most one bit set
halted  out  1  high while in HALT
error  out  1  sticky flag for an illegal sequencer opcode or device id

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values: pc=0 (so rom_addr=0), inst=12'h000, inst_en=0, halted=0, error=0, wait counter=0, state=FETCH. Reset takes priority in every state, including mid-WAIT and in HALT.
- Program word format: dev=rom_data[15:12], op=rom_data[11:8], imm=rom_data[7:0].
- States:
  - FETCH: rom_addr=pc; next state is EXEC.
  - EXEC: decode rom_data.
    - dev in 1..DEVICES: register inst<=rom_data[11:0] and inst_en<=1<<(dev-1); pc<=pc+1; next FETCH.
    - dev=0 with op SEQ_NOP(0): pc<=pc+1; next FETCH.
    - dev=0 with op SEQ_JMP(1): pc<=imm[PC_WIDTH-1:0]; next FETCH. A jump to self is legal and loops forever.
    - dev=0 with op SEQ_WAIT(2): cnt<=imm; pc<=pc+1. If imm=0 go to FETCH; otherwise go to WAIT.
    - dev=0 with op SEQ_HALT(3): next HALT; pc unchanged.
    - dev=0 with any other op, or dev>DEVICES: treat as NOP, set error<=1, inst_en stays 0.
  - WAIT: cnt<=cnt-1; when cnt==1, go to FETCH. Stall length is exactly imm cycles.
  - HALT: halted=1 and inst_en=0; leave only on reset.
- Output timing:
  - inst_en is high for exactly one cycle: the cycle after EXEC, which overlaps the next FETCH.
  - inst holds its last value between dispatches; inst_en is 0 in every other cycle.
  - Peak rate is one device instruction per 2 cycles. A device sees it on the edge that ends the pulse cycle.
- Program counter: pc+1 wraps modulo 2^PC_WIDTH (8'hFF -> 8'h00) silently, with no error.
- error: sticky; cleared only by reset.

Decomposition:
- Shared package holds:
  - sequencer opcodes SEQ_NOP, SEQ_JMP, SEQ_WAIT and SEQ_HALT;
  - the state encoding FETCH, EXEC, WAIT and HALT;
  - word field positions and the device-id width constant (4).
- Device opcodes stay in each device's own package.
- No sub-module; the wait counter and the decode are small enough to live inline.

Test Plan:
1. Dispatch: ROM[0]=16'h11AE, ROM[1]=16'h2122. Release reset. Expect inst_en=4'b0001 with inst=12'h1AE for one cycle, then 2 cycles later inst_en=4'b0010 with inst=12'h122. Pulses are spaced 2 cycles apart.
2. Jump and wrap:
   - ROM[2]=16'h0105 -> the next rom_addr is 5.
   - With PC_WIDTH=8, a NOP at 8'hFF -> rom_addr goes to 8'h00 and error stays 0.
3. Wait: ROM[0]=16'h0203, ROM[1]=16'h1100. The device-1 pulse occurs exactly 3 cycles later than with a 16'h0200 (zero-wait) word in its place.
4. Halt: ROM[0]=16'h0300. halted=1 from the cycle after EXEC; rom_addr stays 0 and inst_en stays 0 for 20 cycles.
5. Illegal words: ROM[0]=16'h0F00, then a dev=5 word with DEVICES=4. error=1 and stays sticky, no inst_en pulse occurs, and pc still advances to 2.
6. Reset mid-operation: assert reset during a WAIT of imm=8'hFF, and separately during HALT. On the next edge all outputs return to their reset values and fetching restarts at address 0.

Source files
------------

// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the inst/inst_en bus sequencer: word fields, sequencer opcodes, FSM states.
// No logic here; latency and flow control live in inst_sequencer.
package inst_sequencer_pkg;

   localparam int DEV_W   = 4;
   localparam int DEV_MSB = 15;
   localparam int DEV_LSB = 12;
   localparam int OP_MSB  = 11;
   localparam int OP_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] SEQ_NOP  = 4'h0;
   localparam logic [3:0] SEQ_JMP  = 4'h1;
   localparam logic [3:0] SEQ_WAIT = 4'h2;
   localparam logic [3:0] SEQ_HALT = 4'h3;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      WAIT  = 2'd2,
      HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/inst_sequencer.sv
// ROM-driven initiator for the inst/inst_en bus: 2 cycles per word, dispatch pulse in the cycle after EXEC.
// No backpressure; devices must accept one instruction every 2 cycles.
module inst_sequencer
   import inst_sequencer_pkg::*;
#(
   parameter int DEVICES  = 4,
   parameter int PC_WIDTH = 8
) (
   input  logic                clock,
   input  logic                reset,
   output logic [PC_WIDTH-1:0] rom_addr,
   input  logic [15:0]         rom_data,
   output logic [11:0]         inst,
   output logic [DEVICES-1:0]  inst_en,
   output logic                halted,
   output logic                error
);

   state_t              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [7:0]          cnt_q;
   logic [11:0]         inst_q;
   logic [DEVICES-1:0]  inst_en_q;
   logic                halted_q;
   logic                error_q;

   logic [DEV_W-1:0]    dev;
   logic [3:0]          op;
   logic [7:0]          imm;
   logic                dev_ok;
   logic [DEVICES-1:0]  dev_onehot;
   logic [PC_WIDTH-1:0] pc_inc;

   assign dev    = rom_data[DEV_MSB:DEV_LSB];
   assign op     = rom_data[OP_MSB:OP_LSB];
   assign imm    = rom_data[IMM_MSB:IMM_LSB];
   assign dev_ok = (dev != '0) && ({28'd0, dev} <= 32'(DEVICES));
   assign pc_inc = pc_q + PC_WIDTH'(1);

   always_comb begin
      dev_onehot = '0;
      for (int i = 0; i < DEVICES; i++) begin
         if ({28'd0, dev} == 32'(i + 1)) dev_onehot[i] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= '0;
         cnt_q     <= '0;
         inst_q    <= '0;
         inst_en_q <= '0;
         halted_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         // Enable is a one-cycle pulse; only a dispatching EXEC raises it.
         inst_en_q <= '0;
         case (state_q)
            FETCH: state_q <= EXEC;
            EXEC: begin
               state_q <= FETCH;
               pc_q    <= pc_inc;
               if (dev_ok) begin
                  inst_q    <= rom_data[11:0];
                  inst_en_q <= dev_onehot;
               end else if (dev == '0) begin
                  case (op)
                     SEQ_NOP: ;
                     SEQ_JMP: pc_q <= PC_WIDTH'(imm);
                     SEQ_WAIT: begin
                        cnt_q <= imm;
                        if (imm != 8'd0) state_q <= WAIT;
                     end
                     SEQ_HALT: begin
                        pc_q     <= pc_q;
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                     end
                     default: error_q <= 1'b1;
                  endcase
               end else begin
                  error_q <= 1'b1;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_q <= FETCH;
            end
            HALT: ;
            default: state_q <= FETCH;
         endcase
      end
   end

   assign rom_addr = pc_q;
   assign inst     = inst_q;
   assign inst_en  = inst_en_q;
   assign halted   = halted_q;
   assign error    = error_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: hand vectors, reset corner cases, and random programs vs an instruction-level model.
// The model counts cycles per instruction (2, plus imm for WAIT) rather than stepping an FSM.
module tb_inst_sequencer;

   localparam int NCYC = 300;

   logic        clock;
   logic        reset;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [11:0] inst;
   logic [3:0]  inst_en;
   logic        halted;
   logic        error;

   logic [15:0] rom [256];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   inst_sequencer #(.DEVICES(4), .PC_WIDTH(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .inst     (inst),
      .inst_en  (inst_en),
      .halted   (halted),
      .error    (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Registered ROM: data for an address appears one cycle later.
   always @(posedge clock) rom_data <= rom[rom_addr];

   typedef struct {
      logic [15:0] w0, w1, w2, wff;
      int          cyc;
      logic [3:0]  en;
      logic [11:0] inst;
      logic [7:0]  addr;
      logic        h;
      logic        e;
   } vec_t;

   vec_t vt [15];

   logic [3:0]  m_en    [NCYC];
   logic [11:0] m_inst  [NCYC];
   logic [7:0]  m_addr  [NCYC];
   logic        m_halt  [NCYC];
   logic        m_err   [NCYC];
   logic        ev_inst [NCYC];
   logic [11:0] ev_ival [NCYC];
   logic        ev_err  [NCYC];
   logic        ev_halt [NCYC];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   // Leaves the bench at the negedge inside cycle 0 (first FETCH at address 0).
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " addr"},   32'(rom_addr), 32'h0);
      chk({nm, " inst"},   32'(inst),     32'h0);
      chk({nm, " en"},     32'(inst_en),  32'h0);
      chk({nm, " halted"}, 32'(halted),   32'h0);
      chk({nm, " error"},  32'(error),    32'h0);
   endtask

   task automatic mark_err(input int c);
      if (c < NCYC) ev_err[c] = 1'b1;
   endtask

   // Instruction-level interpretation of the ROM: each word costs 2 cycles
   // (plus imm for a wait); effects become visible 2 cycles after its fetch.
   task automatic build_model();
      int t, pc, npc, cost, dv, op, imm;
      logic [15:0] w;
      bit stop;
      for (int c = 0; c < NCYC; c++) begin
         m_en[c] = 4'h0; m_addr[c] = 8'h0;
         ev_inst[c] = 1'b0; ev_ival[c] = 12'h0; ev_err[c] = 1'b0; ev_halt[c] = 1'b0;
      end
      t = 0; pc = 0; stop = 1'b0;
      while (t < NCYC && !stop) begin
         w    = rom[pc];
         dv   = int'(w[15:12]);
         op   = int'(w[11:8]);
         imm  = int'(w[7:0]);
         cost = 2;
         npc  = (pc + 1) % 256;
         if (dv >= 1 && dv <= 4) begin
            if (t + 2 < NCYC) begin
               m_en[t + 2]    = 4'(1 << (dv - 1));
               ev_inst[t + 2] = 1'b1;
               ev_ival[t + 2] = w[11:0];
            end
         end else if (dv == 0 && op == 1) begin
            npc = imm;
         end else if (dv == 0 && op == 2) begin
            cost = 2 + imm;
         end else if (dv == 0 && op == 3) begin
            stop = 1'b1;
            npc  = pc;
            if (t + 2 < NCYC) ev_halt[t + 2] = 1'b1;
         end else if (!(dv == 0 && op == 0)) begin
            mark_err(t + 2);
         end
         for (int c = t; c < t + cost && c < NCYC; c++)
            m_addr[c] = (c < t + 2) ? 8'(pc) : 8'(npc);
         t  = t + cost;
         pc = npc;
      end
      if (stop) for (int c = t; c < NCYC; c++) m_addr[c] = 8'(pc);
      begin
         logic [11:0] ci;
         logic ce, ch;
         ci = 12'h0; ce = 1'b0; ch = 1'b0;
         for (int c = 0; c < NCYC; c++) begin
            if (ev_inst[c]) ci = ev_ival[c];
            if (ev_err[c])  ce = 1'b1;
            if (ev_halt[c]) ch = 1'b1;
            m_inst[c] = ci; m_err[c] = ce; m_halt[c] = ch;
         end
      end
   endtask

   function automatic logic [15:0] rand_word();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 50)      return {4'($urandom_range(1, 4)), 12'($urandom)};
      else if (r < 62) return 16'h0000;
      else if (r < 72) return {8'h01, 8'($urandom)};
      else if (r < 84) return {8'h02, 8'($urandom_range(0, 6))};
      else if (r < 87) return {8'h03, 8'($urandom)};
      else if (r < 93) return {4'h0, 4'($urandom_range(4, 15)), 8'($urandom)};
      else             return {4'($urandom_range(5, 15)), 12'($urandom)};
   endfunction

   initial begin
      reset = 1'b1;
      clear_rom();

      // Reset state while reset is still asserted.
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      chk_reset_vals("in_reset");

      //          w0        w1        w2        wff     cyc en    inst     addr   h     e
      vt[0]  = '{16'h11AE, 16'h2122, 16'h0000, 16'h0000,  2, 4'h1, 12'h1AE, 8'h01, 1'b0, 1'b0};
      vt[1]  = '{16'h11AE, 16'h2122, 16'h0000, 16'h0000,  3, 4'h0, 12'h1AE, 8'h01, 1'b0, 1'b0};
      vt[2]  = '{16'h11AE, 16'h2122, 16'h0000, 16'h0000,  4, 4'h2, 12'h122, 8'h02, 1'b0, 1'b0};
      vt[3]  = '{16'h0000, 16'h0000, 16'h0105, 16'h0000,  6, 4'h0, 12'h000, 8'h05, 1'b0, 1'b0};
      vt[4]  = '{16'h01FF, 16'h0000, 16'h0000, 16'h0000,  2, 4'h0, 12'h000, 8'hFF, 1'b0, 1'b0};
      vt[5]  = '{16'h01FF, 16'h0000, 16'h0000, 16'h0000,  4, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0};
      vt[6]  = '{16'h0203, 16'h1100, 16'h0000, 16'h0000,  6, 4'h0, 12'h000, 8'h01, 1'b0, 1'b0};
      vt[7]  = '{16'h0203, 16'h1100, 16'h0000, 16'h0000,  7, 4'h1, 12'h100, 8'h02, 1'b0, 1'b0};
      vt[8]  = '{16'h0200, 16'h1100, 16'h0000, 16'h0000,  4, 4'h1, 12'h100, 8'h02, 1'b0, 1'b0};
      vt[9]  = '{16'h0300, 16'h0000, 16'h0000, 16'h0000,  1, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0};
      vt[10] = '{16'h0300, 16'h0000, 16'h0000, 16'h0000,  2, 4'h0, 12'h000, 8'h00, 1'b1, 1'b0};
      vt[11] = '{16'h0300, 16'h1111, 16'h0000, 16'h0000, 22, 4'h0, 12'h000, 8'h00, 1'b1, 1'b0};
      vt[12] = '{16'h0F00, 16'h5123, 16'h0300, 16'h0000,  2, 4'h0, 12'h000, 8'h01, 1'b0, 1'b1};
      vt[13] = '{16'h0F00, 16'h5123, 16'h0300, 16'h0000,  4, 4'h0, 12'h000, 8'h02, 1'b0, 1'b1};
      vt[14] = '{16'h0F00, 16'h5123, 16'h0300, 16'h0000,  6, 4'h0, 12'h000, 8'h02, 1'b1, 1'b1};

      for (int i = 0; i < 15; i++) begin
         clear_rom();
         rom[0] = vt[i].w0; rom[1] = vt[i].w1; rom[2] = vt[i].w2; rom[255] = vt[i].wff;
         do_reset();
         run_to(vt[i].cyc);
         chk($sformatf("vec%0d en", i),     32'(inst_en),  32'(vt[i].en));
         chk($sformatf("vec%0d inst", i),   32'(inst),     32'(vt[i].inst));
         chk($sformatf("vec%0d addr", i),   32'(rom_addr), 32'(vt[i].addr));
         chk($sformatf("vec%0d halted", i), 32'(halted),   32'(vt[i].h));
         chk($sformatf("vec%0d error", i),  32'(error),    32'(vt[i].e));
      end

      // Halt: nothing dispatched and address frozen for 20 cycles.
      clear_rom();
      rom[0] = 16'h0300; rom[1] = 16'h1111;
      do_reset();
      run_to(2);
      for (int k = 0; k < 20; k++) begin
         chk("halt_hold en",   32'(inst_en),  32'h0);
         chk("halt_hold addr", 32'(rom_addr), 32'h0);
         run_to(cyc + 1);
      end

      // Reset during a long wait, after an error was latched.
      clear_rom();
      rom[0] = 16'h0F00; rom[1] = 16'h02FF; rom[2] = 16'h1ABC;
      do_reset();
      run_to(50);
      chk("mid_wait error", 32'(error),    32'h1);
      chk("mid_wait addr",  32'(rom_addr), 32'h2);
      reset = 1'b1;
      @(negedge clock);
      chk_reset_vals("rst_wait");
      reset = 1'b0;
      cyc = 0;
      run_to(2);
      chk("rst_wait restart addr", 32'(rom_addr), 32'h1);

      // Reset during halt, after a dispatch left inst non-zero.
      clear_rom();
      rom[0] = 16'h1155; rom[1] = 16'h0300;
      do_reset();
      run_to(10);
      chk("mid_halt halted", 32'(halted), 32'h1);
      chk("mid_halt inst",   32'(inst),   32'h155);
      reset = 1'b1;
      @(negedge clock);
      chk_reset_vals("rst_halt");
      reset = 1'b0;
      cyc = 0;
      run_to(2);
      chk("rst_halt redispatch", 32'(inst_en), 32'h1);

      // Random programs against the instruction-level model.
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 256; i++) rom[i] = rand_word();
         build_model();
         do_reset();
         for (int c = 0; c < NCYC; c++) begin
            run_to(c);
            chk($sformatf("rand%0d c%0d en", p, c),     32'(inst_en),  32'(m_en[c]));
            chk($sformatf("rand%0d c%0d inst", p, c),   32'(inst),     32'(m_inst[c]));
            chk($sformatf("rand%0d c%0d addr", p, c),   32'(rom_addr), 32'(m_addr[c]));
            chk($sformatf("rand%0d c%0d halted", p, c), 32'(halted),   32'(m_halt[c]));
            chk($sformatf("rand%0d c%0d error", p, c),  32'(error),    32'(m_err[c]));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
